// File: rtl/btn_event_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
// Shared definitions for the two-button event decoder:
//   - btn_state_e : per-channel FSM state encoding
//   - default debounce / long-press cycle counts (sized for a 50 MHz clock:
//     20 ms debounce, 1 s long press)
//   - cnt_width() : counter width helper so counters can hold every value
//                   up to and including the parameter without wrapping
// -----------------------------------------------------------------------------
package btn_event_pkg;

  localparam int NUM_BUTTONS               = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    LONG_HELD  = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_e;

  // One extra bit over $clog2 keeps the counter from ever wrapping,
  // even when the parameter is an exact power of two.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One push-button channel: 2-flop synchronizer, debounce FSM, hold counter
// and registered event outputs.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   i_btn_n    in   raw button, active low (0 = pressed), asynchronous to clk
//   o_press    out  1-cycle pulse on an accepted press
//   o_release  out  1-cycle pulse on an accepted release
//   o_long     out  1-cycle pulse once the press has lasted LONG_PRESS_CYCLES
//   o_held     out  level, 1 while the button is accepted-pressed
//
// Timing with the button held steadily low: the synchronizer costs two edges,
// IDLE->DB_PRESS costs one, and DB_PRESS needs DEBOUNCE_CYCLES further low
// samples, so o_press rises DEBOUNCE_CYCLES+2 edges after the first edge that
// sampled the low level. Release is symmetric.
// -----------------------------------------------------------------------------
module btn_channel
  import btn_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_held
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // ---------------------------------------------------------------------------
  // Synchronizer: resets to 1 so a reset looks like "released" and a button
  // held through reset has to be debounced again from scratch.
  // ---------------------------------------------------------------------------
  logic r_sync_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
    end else begin
      r_sync_meta <= i_btn_n;
      r_sync      <= r_sync_meta;
    end
  end

  logic w_low;
  assign w_low = ~r_sync;

  // ---------------------------------------------------------------------------
  // Channel FSM with registered outputs
  // ---------------------------------------------------------------------------
  btn_state_e        r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_from_long;  // DB_RELEASE was entered from LONG_HELD
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic              r_held;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_from_long <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      // Event outputs are single-cycle pulses unless set below.
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_low) begin
            r_state  <= DB_PRESS;
            r_db_cnt <= '0;
          end
        end

        DB_PRESS: begin
          if (!w_low) begin
            r_state <= IDLE;
          end else if (r_db_cnt == DB_LAST) begin
            r_state    <= PRESSED;
            r_press    <= 1'b1;
            r_held     <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end

        PRESSED: begin
          if (!w_low) begin
            // Hold counter is left untouched so a bounce resumes the count.
            r_state     <= DB_RELEASE;
            r_db_cnt    <= '0;
            r_from_long <= 1'b0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state <= LONG_HELD;
            r_long  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          end
        end

        LONG_HELD: begin
          // No way back to PRESSED from here, so the long event is one-shot
          // for the lifetime of the accepted press.
          if (!w_low) begin
            r_state     <= DB_RELEASE;
            r_db_cnt    <= '0;
            r_from_long <= 1'b1;
          end
        end

        DB_RELEASE: begin
          if (w_low) begin
            r_state <= r_from_long ? LONG_HELD : PRESSED;
          end else if (r_db_cnt == DB_LAST) begin
            r_state   <= IDLE;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_held    = r_held;

endmodule

// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
// Two independent active-low push-button channels, each turned into clean
// press / release / long-press pulses plus a held level.
//
// Ports
//   clk          in   [1]  system clock
//   reset        in   [1]  asynchronous active-low reset
//   btn          in   [2]  raw buttons, active low; btn[0]=btn1, btn[1]=btn2
//   btn_press    out  [2]  1-cycle pulse per channel on accepted press
//   btn_release  out  [2]  1-cycle pulse per channel on accepted release
//   btn_long     out  [2]  1-cycle pulse per channel after a long hold
//   btn_held     out  [2]  level per channel while accepted-pressed
//
// DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must both be at least 1.
// -----------------------------------------------------------------------------
module btn_event_decoder
  import btn_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_long,
  output logic [NUM_BUTTONS-1:0] btn_held
);

  // All outputs come straight from registers inside each channel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .i_btn_n  (btn[gi]),
        .o_press  (btn_press[gi]),
        .o_release(btn_release[gi]),
        .o_long   (btn_long[gi]),
        .o_held   (btn_held[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_event_decoder.sv
module tb_btn_event_decoder;

  localparam int DB  = 4;
  localparam int LP  = 16;
  // Edges from the first sampling edge to the edge that raises a press/release.
  localparam int LAT = DB + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn = 2'b11;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;
  logic [1:0] btn_held;

  always #5 clk = ~clk;

  btn_event_decoder #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_held   (btn_held)
  );

  typedef struct {
    int         at_edge;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } exp_t;

  exp_t       sb_q[$];
  int         edge_cnt;
  int         tests;
  int         fails;
  logic [1:0] exp_held;

  // Scoreboard push, kept sorted by the edge at which the pulse is due.
  function automatic void push_exp(input int e, input logic [1:0] p,
                                   input logic [1:0] r, input logic [1:0] l);
    exp_t item;
    int   idx;
    item.at_edge = e;
    item.press   = p;
    item.rel     = r;
    item.lng     = l;
    idx = sb_q.size();
    for (int k = 0; k < sb_q.size(); k++) begin
      if (sb_q[k].at_edge > e) begin
        idx = k;
        break;
      end
    end
    sb_q.insert(idx, item);
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_cnt, obs, expv);
    end
  endtask

  // One clock: count the rising edge, then compare on the falling edge.
  task automatic tick();
    logic [1:0] ep;
    logic [1:0] er;
    logic [1:0] el;
    exp_t       it;
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    ep = 2'b00;
    er = 2'b00;
    el = 2'b00;
    while (sb_q.size() > 0 && sb_q[0].at_edge <= edge_cnt) begin
      it = sb_q.pop_front();
      ep = ep | it.press;
      er = er | it.rel;
      el = el | it.lng;
      $display("[TB] edge %0d expect press=%b release=%b long=%b",
               edge_cnt, it.press, it.rel, it.lng);
    end
    exp_held = (exp_held | ep) & ~er;
    check("press",   btn_press,   ep);
    check("release", btn_release, er);
    check("long",    btn_long,    el);
    check("held",    btn_held,    exp_held);
  endtask

  task automatic run_to(input int n);
    while (edge_cnt < n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_press"},   btn_press,   2'b00);
    check({tag, "_release"}, btn_release, 2'b00);
    check({tag, "_long"},    btn_long,    2'b00);
    check({tag, "_held"},    btn_held,    2'b00);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    edge_cnt = 0;
    exp_held = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst_state");
    reset = 1'b1;

    // Ch0 low steadily from edge 10; ch1 low for edges 10..12 only (glitch)
    run_to(9);
    btn = 2'b00;
    push_exp(edge_cnt + 1 + LAT, 2'b01, 2'b00, 2'b00);
    push_exp(edge_cnt + 1 + LAT + LP, 2'b00, 2'b00, 2'b01);
    run_to(12);
    btn[1] = 1'b1;
    run_to(40);

    // Ch0 bounces high for 2 cycles while in LONG_HELD: no event
    btn[0] = 1'b1;
    run_to(42);
    btn[0] = 1'b0;
    run_to(50);

    // Ch0 steady release
    btn[0] = 1'b1;
    push_exp(edge_cnt + 1 + LAT, 2'b00, 2'b01, 2'b00);
    run_to(60);

    // Both pressed on the same edge, released together before long press
    btn = 2'b00;
    push_exp(edge_cnt + 1 + LAT, 2'b11, 2'b00, 2'b00);
    run_to(75);
    btn = 2'b11;
    push_exp(edge_cnt + 1 + LAT, 2'b00, 2'b11, 2'b00);
    run_to(110);

    // Ch0 to LONG_HELD, then reset with the button still low
    btn[0] = 1'b0;
    push_exp(edge_cnt + 1 + LAT, 2'b01, 2'b00, 2'b00);
    push_exp(edge_cnt + 1 + LAT + LP, 2'b00, 2'b00, 2'b01);
    run_to(140);
    reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    sb_q.delete();
    exp_held = 2'b00;
    repeat (3) @(negedge clk);
    check_all_zero("rst_hold");
    reset = 1'b1;
    edge_cnt = 0;
    push_exp(1 + LAT, 2'b01, 2'b00, 2'b00);
    push_exp(1 + LAT + LP, 2'b00, 2'b00, 2'b01);
    run_to(30);
    btn[0] = 1'b1;
    push_exp(edge_cnt + 1 + LAT, 2'b00, 2'b01, 2'b00);
    run_to(45);

    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
